// File: rtl/pill_dispense_sequencer.sv
// Purpose : per-pill / per-bottle req-ack sequencer feeding the counting and display path.
// Latency : every output is registered; a start, ack or clear shows on the outputs one edge later.
// Backpressure: a request is held until it is acked. in_suspend stops new pill requests.
//           A req left unacked for ACK_TIMEOUT cycles parks the block in FAULT.
//
// Ports
//   in_clk, in_reset           clock, synchronous active-high reset
//   in_start                   one-cycle run request; the targets are latched here
//   in_suspend                 level; holds out_pill_req low and freezes the timeout
//   in_clear                   one-cycle abort/acknowledge back to IDLE (highest priority)
//   in_target_bottle_num       bottles per batch
//   in_target_pill_num         pills per bottle
//   in_pill_ack / in_bottle_ack  handshake returns from the dispenser and the conveyor
//   out_pill_req / out_bottle_req  level requests to the dispenser and the conveyor
//   out_pill_num / out_bottle_num  live counts
//   out_next_bottle            one-cycle strobe for each completed bottle
//   out_finish / out_fault     levels; batch complete / handshake timeout
//   out_cfg_err                one-cycle strobe; a start was refused because a target is zero

module pill_dispense_sequencer #(
  parameter int CNT_W       = 6,
  parameter int ACK_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic             in_clk,
  input  logic             in_reset,
  input  logic             in_start,
  input  logic             in_suspend,
  input  logic             in_clear,
  input  logic [CNT_W-1:0] in_target_bottle_num,
  input  logic [CNT_W-1:0] in_target_pill_num,
  input  logic             in_pill_ack,
  input  logic             in_bottle_ack,
  output logic             out_pill_req,
  output logic             out_bottle_req,
  output logic [CNT_W-1:0] out_pill_num,
  output logic [CNT_W-1:0] out_bottle_num,
  output logic             out_next_bottle,
  output logic             out_finish,
  output logic             out_fault,
  output logic             out_cfg_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_GAP    = 3'd2;
  localparam logic [2:0] S_CHANGE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  // The last count value that is still allowed. An unacked req seen at this
  // value means the req has now been high for ACK_TIMEOUT cycles.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_tgt_pill;
  logic [CNT_W-1:0] r_tgt_bottle;
  logic [CNT_W-1:0] r_pill_num;
  logic [CNT_W-1:0] r_bottle_num;
  logic [TO_W-1:0]  r_to;
  logic             r_pill_req;
  logic             r_bottle_req;
  logic             r_next_bottle;
  logic             r_finish;
  logic             r_fault;
  logic             r_cfg_err;

  logic [2:0]       w_nxt_state;
  logic [CNT_W-1:0] w_nxt_tgt_pill;
  logic [CNT_W-1:0] w_nxt_tgt_bottle;
  logic [CNT_W-1:0] w_nxt_pill;
  logic [CNT_W-1:0] w_nxt_bottle;
  logic [TO_W-1:0]  w_nxt_to;
  logic             w_nxt_next_bottle;
  logic             w_nxt_cfg_err;
  logic             w_nxt_pill_req;
  logic             w_nxt_bottle_req;
  logic [CNT_W-1:0] w_pill_inc;
  logic [CNT_W-1:0] w_bottle_inc;
  logic             w_targets_ok;

  assign w_pill_inc   = r_pill_num + CNT_W'(1);
  assign w_bottle_inc = r_bottle_num + CNT_W'(1);
  assign w_targets_ok = (in_target_pill_num != '0) && (in_target_bottle_num != '0);

  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_tgt_pill    = r_tgt_pill;
    w_nxt_tgt_bottle  = r_tgt_bottle;
    w_nxt_pill        = r_pill_num;
    w_nxt_bottle      = r_bottle_num;
    w_nxt_to          = r_to;
    w_nxt_next_bottle = 1'b0;
    w_nxt_cfg_err     = 1'b0;

    if (in_clear) begin
      // Clear outranks start and any ack arriving in the same cycle.
      w_nxt_state  = S_IDLE;
      w_nxt_pill   = '0;
      w_nxt_bottle = '0;
      w_nxt_to     = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_start) begin
            if (w_targets_ok) begin
              w_nxt_tgt_pill   = in_target_pill_num;
              w_nxt_tgt_bottle = in_target_bottle_num;
              w_nxt_pill       = '0;
              w_nxt_bottle     = '0;
              w_nxt_to         = '0;
              w_nxt_state      = S_REQ;
            end else begin
              w_nxt_cfg_err = 1'b1;
            end
          end
        end

        S_REQ: begin
          // Acks count only against a req that is actually on the wire. While
          // suspended the req is low, so the timeout counter stays where it is.
          if (r_pill_req) begin
            if (in_pill_ack) begin
              w_nxt_pill  = w_pill_inc;
              w_nxt_to    = '0;
              w_nxt_state = (w_pill_inc == r_tgt_pill) ? S_CHANGE : S_GAP;
            end else if (r_to == TO_LAST) begin
              w_nxt_to    = '0;
              w_nxt_state = S_FAULT;
            end else begin
              w_nxt_to = r_to + TO_W'(1);
            end
          end
        end

        S_GAP: begin
          // One dead cycle between requests gives the dispenser a clean low pulse.
          w_nxt_to    = '0;
          w_nxt_state = S_REQ;
        end

        S_CHANGE: begin
          if (r_bottle_req) begin
            if (in_bottle_ack) begin
              w_nxt_bottle      = w_bottle_inc;
              w_nxt_pill        = '0;
              w_nxt_to          = '0;
              w_nxt_next_bottle = 1'b1;
              w_nxt_state       = (w_bottle_inc == r_tgt_bottle) ? S_DONE : S_GAP;
            end else if (r_to == TO_LAST) begin
              w_nxt_to    = '0;
              w_nxt_state = S_FAULT;
            end else begin
              w_nxt_to = r_to + TO_W'(1);
            end
          end
        end

        S_DONE, S_FAULT: begin
          // Counts are held; only clear or reset leaves these states.
        end

        default: begin
          w_nxt_state  = S_IDLE;
          w_nxt_pill   = '0;
          w_nxt_bottle = '0;
          w_nxt_to     = '0;
        end
      endcase
    end
  end

  // The request levels come from the next state, so they are registered
  // together with it. Suspend affects only the pill request.
  assign w_nxt_pill_req   = (w_nxt_state == S_REQ) && !in_suspend;
  assign w_nxt_bottle_req = (w_nxt_state == S_CHANGE);

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      r_state       <= S_IDLE;
      r_tgt_pill    <= '0;
      r_tgt_bottle  <= '0;
      r_pill_num    <= '0;
      r_bottle_num  <= '0;
      r_to          <= '0;
      r_pill_req    <= 1'b0;
      r_bottle_req  <= 1'b0;
      r_next_bottle <= 1'b0;
      r_finish      <= 1'b0;
      r_fault       <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_tgt_pill    <= w_nxt_tgt_pill;
      r_tgt_bottle  <= w_nxt_tgt_bottle;
      r_pill_num    <= w_nxt_pill;
      r_bottle_num  <= w_nxt_bottle;
      r_to          <= w_nxt_to;
      r_pill_req    <= w_nxt_pill_req;
      r_bottle_req  <= w_nxt_bottle_req;
      r_next_bottle <= w_nxt_next_bottle;
      r_finish      <= (w_nxt_state == S_DONE);
      r_fault       <= (w_nxt_state == S_FAULT);
      r_cfg_err     <= w_nxt_cfg_err;
    end
  end

  assign out_pill_req    = r_pill_req;
  assign out_bottle_req  = r_bottle_req;
  assign out_pill_num    = r_pill_num;
  assign out_bottle_num  = r_bottle_num;
  assign out_next_bottle = r_next_bottle;
  assign out_finish      = r_finish;
  assign out_fault       = r_fault;
  assign out_cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_pill_dispense_sequencer.sv
// Purpose : testbench for pill_dispense_sequencer. It uses a table of single-cycle
//           vectors, hand-written corner sequences, and randomised batches that
//           are scored against counts of accepted handshakes.
module tb_pill_dispense_sequencer;

  logic       in_clk;
  logic       in_reset;
  logic       in_start;
  logic       in_suspend;
  logic       in_clear;
  logic [5:0] in_target_bottle_num;
  logic [5:0] in_target_pill_num;
  logic       in_pill_ack;
  logic       in_bottle_ack;
  logic       out_pill_req;
  logic       out_bottle_req;
  logic [5:0] out_pill_num;
  logic [5:0] out_bottle_num;
  logic       out_next_bottle;
  logic       out_finish;
  logic       out_fault;
  logic       out_cfg_err;

  int n_chk = 0;
  int n_err = 0;

  pill_dispense_sequencer #(.CNT_W(6), .ACK_TIMEOUT(15), .TO_W(4)) dut (
    .in_clk               (in_clk),
    .in_reset             (in_reset),
    .in_start             (in_start),
    .in_suspend           (in_suspend),
    .in_clear             (in_clear),
    .in_target_bottle_num (in_target_bottle_num),
    .in_target_pill_num   (in_target_pill_num),
    .in_pill_ack          (in_pill_ack),
    .in_bottle_ack        (in_bottle_ack),
    .out_pill_req         (out_pill_req),
    .out_bottle_req       (out_bottle_req),
    .out_pill_num         (out_pill_num),
    .out_bottle_num       (out_bottle_num),
    .out_next_bottle      (out_next_bottle),
    .out_finish           (out_finish),
    .out_fault            (out_fault),
    .out_cfg_err          (out_cfg_err)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  typedef struct {
    int start, clear, susp, pack, back, tp, tb;
    int preq, breq, pn, bn, nb, fin, flt, cerr;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(negedge in_clk);
  endtask

  task automatic idle_inputs();
    in_start = 0; in_clear = 0; in_suspend = 0; in_pill_ack = 0; in_bottle_ack = 0;
  endtask

  task automatic do_start(input int tp, input int tb);
    in_target_pill_num   = 6'(tp);
    in_target_bottle_num = 6'(tb);
    in_start = 1;
    step();
    in_start = 0;
  endtask

  task automatic do_clear();
    in_clear = 1;
    step();
    in_clear = 0;
  endtask

  // Automatic responder plus scoreboard. P and B count the handshakes the
  // dispenser and the conveyor actually completed. From these, the expected
  // live counts are bottles = B and pills = P - B*tp.
  task automatic auto_run(input int tp, input int dly, input int susp_pct, input int max_cyc,
                          output int n_rise, output int n_nb, output int p_tot, output int b_tot);
    int  pc, bc;
    bit  prev_req, acc_p, acc_b;
    pc = 0; bc = 0; prev_req = 0; acc_p = 0; acc_b = 0;
    n_rise = 0; n_nb = 0; p_tot = 0; b_tot = 0;
    for (int c = 0; c < max_cyc && !out_finish && !out_fault; c++) begin
      chk("auto_bottle_num", out_bottle_num, b_tot);
      chk("auto_pill_num", out_pill_num, p_tot - b_tot * tp);
      chk("auto_next_bottle", out_next_bottle, acc_b);
      chk("auto_req_exclusive", out_pill_req & out_bottle_req, 0);
      if (acc_p) chk("auto_gap_after_pill", out_pill_req, 0);
      if (out_pill_req && !prev_req) n_rise++;
      prev_req = out_pill_req;
      n_nb += out_next_bottle;
      in_suspend = ($urandom_range(99) < susp_pct);
      in_pill_ack = 0;
      in_bottle_ack = 0;
      if (out_pill_req) begin
        if (pc >= dly) begin in_pill_ack = 1; pc = 0; end
        else pc++;
      end
      if (out_bottle_req) begin
        if (bc >= dly) begin in_bottle_ack = 1; bc = 0; end
        else bc++;
      end
      acc_p = out_pill_req && in_pill_ack;
      acc_b = out_bottle_req && in_bottle_ack;
      p_tot += int'(acc_p);
      b_tot += int'(acc_b);
      step();
    end
    idle_inputs();
    chk("auto_end_next_bottle", out_next_bottle, acc_b);
    chk("auto_end_bottle_num", out_bottle_num, b_tot);
    chk("auto_end_pill_num", out_pill_num, p_tot - b_tot * tp);
    n_nb += out_next_bottle;
  endtask

  vec_t vecs[18];

  initial begin
    int n_rise, n_nb, p_tot, b_tot, hi_cnt, tp, tb, dly;

    //          start clr susp pack back tp tb | preq breq pn bn nb fin flt cerr
    vecs[0]  = '{0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 0, 0, 2,   0, 0, 0, 0, 0, 0, 0, 1};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 2,   0, 0, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{1, 0, 0, 0, 0, 2, 0,   0, 0, 0, 0, 0, 0, 0, 1};
    vecs[4]  = '{0, 0, 0, 1, 0, 2, 0,   0, 0, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{1, 0, 0, 0, 0, 1, 1,   1, 0, 0, 0, 0, 0, 0, 0};
    vecs[6]  = '{0, 0, 0, 1, 0, 1, 1,   0, 1, 1, 0, 0, 0, 0, 0};
    vecs[7]  = '{0, 0, 0, 0, 1, 1, 1,   0, 0, 0, 1, 1, 1, 0, 0};
    vecs[8]  = '{0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 1, 0, 1, 0, 0};
    vecs[9]  = '{1, 0, 0, 0, 0, 1, 1,   0, 0, 0, 1, 0, 1, 0, 0};
    vecs[10] = '{0, 1, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0, 0, 0};
    vecs[11] = '{1, 0, 1, 0, 0, 1, 2,   0, 0, 0, 0, 0, 0, 0, 0};
    vecs[12] = '{0, 0, 1, 1, 0, 1, 2,   0, 0, 0, 0, 0, 0, 0, 0};
    vecs[13] = '{0, 0, 0, 0, 0, 1, 2,   1, 0, 0, 0, 0, 0, 0, 0};
    vecs[14] = '{0, 0, 0, 1, 0, 1, 2,   0, 1, 1, 0, 0, 0, 0, 0};
    vecs[15] = '{0, 0, 0, 0, 1, 1, 2,   0, 0, 0, 1, 1, 0, 0, 0};
    vecs[16] = '{0, 0, 0, 0, 0, 1, 2,   1, 0, 0, 1, 0, 0, 0, 0};
    vecs[17] = '{0, 1, 0, 1, 0, 1, 2,   0, 0, 0, 0, 0, 0, 0, 0};

    idle_inputs();
    in_target_pill_num = 6'd0;
    in_target_bottle_num = 6'd0;
    in_reset = 1;
    repeat (3) step();
    chk("reset_pill_req", out_pill_req, 0);
    chk("reset_bottle_req", out_bottle_req, 0);
    chk("reset_pill_num", out_pill_num, 0);
    chk("reset_bottle_num", out_bottle_num, 0);
    chk("reset_flags", {out_next_bottle, out_finish, out_fault, out_cfg_err}, 0);
    in_reset = 0;
    step();

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 18; i++) begin
      in_start             = (vecs[i].start != 0);
      in_clear             = (vecs[i].clear != 0);
      in_suspend           = (vecs[i].susp != 0);
      in_pill_ack          = (vecs[i].pack != 0);
      in_bottle_ack        = (vecs[i].back != 0);
      in_target_pill_num   = 6'(vecs[i].tp);
      in_target_bottle_num = 6'(vecs[i].tb);
      step();
      chk($sformatf("vec%0d_pill_req", i), out_pill_req, vecs[i].preq);
      chk($sformatf("vec%0d_bottle_req", i), out_bottle_req, vecs[i].breq);
      chk($sformatf("vec%0d_pill_num", i), out_pill_num, vecs[i].pn);
      chk($sformatf("vec%0d_bottle_num", i), out_bottle_num, vecs[i].bn);
      chk($sformatf("vec%0d_next_bottle", i), out_next_bottle, vecs[i].nb);
      chk($sformatf("vec%0d_finish", i), out_finish, vecs[i].fin);
      chk($sformatf("vec%0d_fault", i), out_fault, vecs[i].flt);
      chk($sformatf("vec%0d_cfg_err", i), out_cfg_err, vecs[i].cerr);
    end
    idle_inputs();
    step();

    // 3 pills x 2 bottles, each request acked on its third high cycle.
    do_start(3, 2);
    auto_run(3, 2, 0, 300, n_rise, n_nb, p_tot, b_tot);
    chk("batch_pill_req_pulses", n_rise, 6);
    chk("batch_next_bottle_strobes", n_nb, 2);
    chk("batch_finish", out_finish, 1);
    chk("batch_pill_num", out_pill_num, 0);
    chk("batch_bottle_num", out_bottle_num, 2);
    step();
    chk("done_holds_finish", out_finish, 1);
    do_clear();
    chk("clear_from_done_finish", out_finish, 0);
    chk("clear_from_done_bottle_num", out_bottle_num, 0);

    // Unacked request times out into FAULT.
    do_start(2, 1);
    hi_cnt = 0;
    for (int c = 0; c < 40 && !out_fault; c++) begin
      if (out_pill_req) hi_cnt++;
      step();
    end
    chk("timeout_req_high_cycles", hi_cnt, 15);
    chk("timeout_fault", out_fault, 1);
    chk("timeout_req_low", out_pill_req, 0);
    step();
    chk("fault_held", out_fault, 1);
    do_clear();
    chk("fault_cleared", out_fault, 0);
    step();
    chk("fault_clear_idle_req", out_pill_req, 0);

    // Ten suspended cycles in the middle of a request.
    do_start(2, 1);
    chk("susp_req_before", out_pill_req, 1);
    step(); step();
    in_suspend = 1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("susp_req_low", out_pill_req, 0);
      chk("susp_no_fault", out_fault, 0);
    end
    in_suspend = 0;
    step();
    chk("susp_release_req", out_pill_req, 1);
    auto_run(2, 2, 0, 200, n_rise, n_nb, p_tot, b_tot);
    chk("susp_batch_finish", out_finish, 1);
    chk("susp_batch_fault", out_fault, 0);
    chk("susp_batch_bottles", out_bottle_num, 1);
    do_clear();

    // Clear in the same cycle as the ack for the second pill of four.
    do_start(4, 1);
    in_pill_ack = 1;
    step();
    in_pill_ack = 0;
    chk("clrack_first_pill", out_pill_num, 1);
    step();
    chk("clrack_second_req", out_pill_req, 1);
    in_pill_ack = 1;
    in_clear = 1;
    step();
    idle_inputs();
    chk("clrack_pill_num", out_pill_num, 0);
    chk("clrack_pill_req", out_pill_req, 0);
    step();
    chk("clrack_stays_idle", out_pill_req, 0);

    // Targets edited after the start are ignored.
    do_start(2, 2);
    in_target_pill_num = 6'd5;
    in_target_bottle_num = 6'd5;
    auto_run(2, 1, 0, 300, n_rise, n_nb, p_tot, b_tot);
    chk("retarget_finish", out_finish, 1);
    chk("retarget_bottle_num", out_bottle_num, 2);
    chk("retarget_pill_num", out_pill_num, 0);
    chk("retarget_pills_dispensed", p_tot, 4);
    chk("retarget_next_bottle_strobes", n_nb, 2);
    do_clear();

    // Random batches with random ack latency and random suspend.
    for (int it = 0; it < 8; it++) begin
      tp  = int'($urandom_range(4, 1));
      tb  = int'($urandom_range(4, 1));
      dly = int'($urandom_range(4, 0));
      do_start(tp, tb);
      auto_run(tp, dly, 25, 800, n_rise, n_nb, p_tot, b_tot);
      chk($sformatf("rand%0d_finish", it), out_finish, 1);
      chk($sformatf("rand%0d_fault", it), out_fault, 0);
      chk($sformatf("rand%0d_pills", it), p_tot, tp * tb);
      chk($sformatf("rand%0d_bottles", it), b_tot, tb);
      chk($sformatf("rand%0d_strobes", it), n_nb, tb);
      chk($sformatf("rand%0d_pill_num", it), out_pill_num, 0);
      do_clear();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
